spi_a2d_model_n: RTL and testbench

- Parametrised, clocked model of the DE0 on-board SPI A2D converter, the successor to the fixed three-value ADC128S model.
- Provides NUM_CH independently writable channel registers of DATA_W bits, replacing the fixed load-cell and battery inputs.
- Adds an optional auto-ramp mode, out-of-range channel flagging and a completed-frame counter.
- Sits on the A2D SPI bus opposite the Segway A2D interface in system benches, and is usable standalone in unit benches.

---
 rtl/spi_a2d_model_n.sv | 157 +++++++++++++++
 tb/tb_spi_a2d_model_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_a2d_model_n.sv
// Clocked behavioural model of the DE0 SPI A2D converter. Holds NUM_CH
// writable channel registers, answers each 16-bit SPI frame with the channel
// addressed in the previous frame, and optionally ramps the read channel down.
module spi_a2d_model_n #(
  parameter int          NUM_CH    = 8,
  parameter int          DATA_W    = 12,
  parameter logic [15:0] INIT_VAL  = 16'h0C00,
  parameter int          RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr,
  input  logic [2:0]        wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ramp_en,
  output logic [15:0]       conv_cnt,
  output logic [2:0]        last_ch,
  output logic              ch_err
);

  localparam logic [DATA_W-1:0] INIT_D = DATA_W'(INIT_VAL);
  localparam logic [DATA_W-1:0] RAMP_D = DATA_W'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, next_state;

  // Synchroniser stages for the asynchronous SPI pins
  logic ss_ff1, ss_n_s, ss_n_d;
  logic sclk_ff1, sclk_s, sclk_d;
  logic mosi_ff1, mosi_s;

  logic [15:0]       tx_shift;
  logic [15:0]       rx_shift;
  logic [4:0]        bit_cnt;
  logic [2:0]        pend_ch;
  // Sized to the full 3-bit address space so any channel index is legal;
  // entries at or above NUM_CH are never written and stay constant.
  logic [DATA_W-1:0] chan [8];

  logic       ss_fall, sclk_rise, sclk_fall;
  logic [2:0] rx_ch;
  logic       wr_ok, ramp_hit;

  function automatic logic ch_ok(input logic [2:0] c);
    return 32'(c) < NUM_CH;
  endfunction

  assign ss_fall   = ss_n_d & ~ss_n_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_ch     = rx_shift[13:11];
  assign wr_ok     = wr & ch_ok(wr_ch);
  assign ramp_hit  = (state == DONE) & ramp_en & ch_ok(pend_ch);
  assign MISO      = (state == SHIFT) ? tx_shift[15] : 1'b0;

  // Double-flop the SPI pins into clk; extra SS_n/SCLK stage for edge detect
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_ff1   <= 1'b1;
      ss_n_s   <= 1'b1;
      ss_n_d   <= 1'b1;
      sclk_ff1 <= 1'b0;
      sclk_s   <= 1'b0;
      sclk_d   <= 1'b0;
      mosi_ff1 <= 1'b0;
      mosi_s   <= 1'b0;
    end else begin
      ss_ff1   <= SS_n;
      ss_n_s   <= ss_ff1;
      ss_n_d   <= ss_n_s;
      sclk_ff1 <= SCLK;
      sclk_s   <= sclk_ff1;
      sclk_d   <= sclk_s;
      mosi_ff1 <= MOSI;
      mosi_s   <= mosi_ff1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (ss_fall) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (ss_n_s) next_state = (bit_cnt >= 5'd16) ? DONE : IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame shift registers and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (state == LOAD) begin
      tx_shift <= ch_ok(pend_ch) ? 16'(chan[pend_ch]) : 16'h0000;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (state == SHIFT) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[14:0], mosi_s};
        if (bit_cnt != 5'h1F) bit_cnt <= bit_cnt + 5'd1;
      end
      // No shift before the first rise: bit 15 must be presented first
      if (sclk_fall && bit_cnt != 5'd0) tx_shift <= {tx_shift[14:0], 1'b0};
    end
  end

  // Completed-frame bookkeeping: pointer, last address, error flag, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ch  <= '0;
      last_ch  <= '0;
      ch_err   <= 1'b0;
      conv_cnt <= '0;
    end else if (state == DONE) begin
      pend_ch  <= rx_ch;
      last_ch  <= rx_ch;
      if (!ch_ok(rx_ch)) ch_err <= 1'b1;
      conv_cnt <= conv_cnt + 16'd1;
    end
  end

  // Channel registers: bench writes take priority over the ramp decrement
  // NOTE: this array is a handful of flops, not a RAM, so it is reset like
  // any other register; a real memory macro would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) chan[i] <= INIT_D;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_ok && wr_ch == 3'(i))
          chan[i] <= wr_data;
        else if (ramp_hit && pend_ch == 3'(i))
          chan[i] <= chan[i] - RAMP_D;
      end
    end
  end

endmodule

// File: tb/tb_spi_a2d_model_n.sv
// Self-checking bench for spi_a2d_model_n: directed frames from the test plan
// followed by randomized frames, all compared with a frame-level model.
module tb_spi_a2d_model_n;

  localparam int NCH = 6;
  localparam int DW  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          SS_n, SCLK, MOSI, MISO;
  logic          wr;
  logic [2:0]    wr_ch;
  logic [DW-1:0] wr_data;
  logic          ramp_en;
  logic [15:0]   conv_cnt;
  logic [2:0]    last_ch;
  logic          ch_err;

  spi_a2d_model_n #(
    .NUM_CH(NCH), .DATA_W(DW), .INIT_VAL(16'h0C00), .RAMP_STEP(16)
  ) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data), .ramp_en(ramp_en),
    .conv_cnt(conv_cnt), .last_ch(last_ch), .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model
  int unsigned m_ch [8];
  int unsigned m_pend, m_last, m_cnt;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = 'hC00;
    m_pend = 0; m_last = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_write(input logic [2:0] c, input logic [DW-1:0] d);
    if (c < NCH) m_ch[c] = d;
  endtask

  task automatic bus_write(input logic [2:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    wr = 1'b1; wr_ch = c; wr_data = d;
    @(negedge clk);
    wr = 1'b0;
    model_write(c, d);
  endtask

  // Runs one frame of nbits SCLK rises sending stream MSB-first.
  // wr_mode: 0 none, 1 write during bit 4, 2 write in the clk the frame completes.
  task automatic spi_frame(input logic [31:0] stream, input int nbits, input int wr_mode,
                           input logic [2:0] wch, input logic [DW-1:0] wdat, input string tag);
    logic [15:0] rx;
    int unsigned exp, old, a;
    exp = (m_pend < NCH) ? m_ch[m_pend] : 0;
    rx  = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = stream[nbits-1-i];
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      if (i < 16) rx[15-i] = MISO;
      if (wr_mode == 1 && i == 4) begin
        wr = 1'b1; wr_ch = wch; wr_data = wdat;
        @(negedge clk);
        wr = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      SCLK = 1'b0;
    end
    repeat (8) @(negedge clk);
    SS_n = 1'b1;
    if (wr_mode == 2) begin
      repeat (3) @(negedge clk);
      wr = 1'b1; wr_ch = wch; wr_data = wdat;
      @(negedge clk);
      wr = 1'b0;
      repeat (8) @(negedge clk);
    end else begin
      repeat (12) @(negedge clk);
    end

    if (wr_mode == 1) model_write(wch, wdat);
    if (nbits >= 16) begin
      a      = stream[13:11];
      old    = m_pend;
      m_last = a;
      if (a >= NCH) m_err = 1;
      m_cnt  = (m_cnt + 1) % 65536;
      if (ramp_en && old < NCH && !(wr_mode == 2 && wch == old))
        m_ch[old] = (m_ch[old] + 4096 - 16) % 4096;
      if (wr_mode == 2) model_write(wch, wdat);
      m_pend = a;
      check({tag, " miso"}, 32'(rx), exp);
    end else if (wr_mode == 2) begin
      model_write(wch, wdat);
    end
    check({tag, " conv_cnt"}, 32'(conv_cnt), m_cnt);
    check({tag, " last_ch"},  32'(last_ch),  m_last);
    check({tag, " ch_err"},   32'(ch_err),   32'(m_err));
  endtask

  function automatic logic [31:0] addr_word(input logic [2:0] c);
    return {16'h0, 2'b00, c, 11'h000};
  endfunction

  initial begin
    logic [31:0] stream;
    logic [2:0]  a, wc;
    int          nb, mode;

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wr = 1'b0; wr_ch = '0; wr_data = '0; ramp_en = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset MISO",     32'(MISO),     0);
    check("reset conv_cnt", 32'(conv_cnt), 0);
    check("reset last_ch",  32'(last_ch),  0);
    check("reset ch_err",   32'(ch_err),   0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // First frame returns ch0 INIT_VAL and addresses ch3
    spi_frame(32'h1800, 16, 0, 0, 0, "first");
    check("first cnt const", 32'(conv_cnt), 1);
    check("first last const", 32'(last_ch), 3);

    // Pending ch3 is rewritten before the frame that reads it
    bus_write(3, 12'h400);
    spi_frame(addr_word(0), 16, 0, 0, 0, "wr ch3");

    // Ramp: three frames addressing ch5
    ramp_en = 1'b1;
    bus_write(5, 12'h010);
    spi_frame(addr_word(5), 16, 0, 0, 0, "ramp1");
    spi_frame(addr_word(5), 16, 0, 0, 0, "ramp2");
    spi_frame(addr_word(5), 16, 0, 0, 0, "ramp3");
    check("ramp wrap model", m_ch[5], 12'hFF0);
    spi_frame(addr_word(1), 16, 0, 0, 0, "ramp read");
    ramp_en = 1'b0;

    // Out-of-range addresses and ignored writes
    spi_frame(addr_word(7), 16, 0, 0, 0, "bad addr");
    bus_write(6, 12'h123);
    spi_frame(addr_word(2), 16, 0, 0, 0, "bad resp");

    // Aborted frame after 9 rises leaves everything alone
    spi_frame(addr_word(4), 9, 0, 0, 0, "abort");
    spi_frame(addr_word(0), 16, 0, 0, 0, "post abort");

    // Write in flight to the loaded channel does not disturb the frame
    spi_frame(addr_word(2), 16, 1, 0, 12'h777, "mid write");
    // Collision of write and ramp decrement on ch2
    ramp_en = 1'b1;
    spi_frame(addr_word(2), 16, 0, 0, 0, "pre collide");
    spi_frame(addr_word(3), 16, 2, 2, 12'hABC, "collide");
    check("collide model", m_ch[2], 12'hABC);
    spi_frame(addr_word(4), 16, 0, 0, 0, "collide read");

    // Overlong frame: channel field comes from the last 16 bits
    spi_frame({8'hFF, 16'h0800 | 16'h0000, 8'h00} >> 8 | 32'h00FF_0000 | addr_word(1),
              24, 0, 0, 0, "overlong");

    // Randomized frames
    for (int k = 0; k < 50; k++) begin
      ramp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        bus_write(3'($urandom_range(0, 7)), DW'($urandom));
      a    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, NCH-1));
      wc   = ($urandom_range(0, 1) == 0) ? 3'(m_pend) : 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 2);
      case ($urandom_range(0, 7))
        0:       nb = $urandom_range(1, 15);
        1:       nb = 16 + $urandom_range(1, 8);
        default: nb = 16;
      endcase
      stream = $urandom;
      stream[13:11] = a;
      spi_frame(stream, nb, mode, wc, DW'($urandom), $sformatf("rand%0d", k));
    end

    // Reset asserted at bit 7 of a frame
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      MOSI = 1'($urandom);
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst MISO",     32'(MISO),     0);
    check("midrst conv_cnt", 32'(conv_cnt), 0);
    check("midrst last_ch",  32'(last_ch),  0);
    check("midrst ch_err",   32'(ch_err),   0);
    SS_n = 1'b1; ramp_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    for (int i = 1; i <= NCH; i++)
      spi_frame(addr_word(3'(i % NCH)), 16, 0, 0, 0, $sformatf("post rst ch%0d", i - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
